// File: rtl/page_access_incr_if.sv
// Request-FIFO and counter-buffer SRAM signals of the page access counter.
// The slave view belongs to page_access_incr; the master view is the
// surrounding logic (request FIFO and the SRAM shared with mem_updater).
interface page_access_incr_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 512
);
    logic              req_valid;
    logic [63:0]       req_addr;
    logic              req_ready;
    logic [ADDR_W-1:0] buf_rdaddress;
    logic [DATA_W-1:0] buf_q;
    logic [ADDR_W-1:0] buf_wraddress;
    logic [DATA_W-1:0] buf_data;
    logic              buf_wren;

    modport slave (
        input  req_valid, req_addr, buf_q,
        output req_ready, buf_rdaddress, buf_wraddress, buf_data, buf_wren
    );

    modport master (
        output req_valid, req_addr, buf_q,
        input  req_ready, buf_rdaddress, buf_wraddress, buf_data, buf_wren
    );
endinterface

// File: rtl/page_access_incr.sv
// Page access counter: pops host access addresses, maps each one to a packed
// 16-bit per-page counter and does a saturating read-modify-write on the SRAM
// word holding it. Drains and parks on pause_req so mem_updater can own the SRAM.
module page_access_incr #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 512,
    parameter int CNT_W      = 16,
    parameter int PAGE_SHIFT = 12
) (
    input  logic        mclk,
    input  logic        reset_n,
    input  logic [63:0] region_base,
    input  logic        hold_reqfifo,
    input  logic        pause_req,
    output logic        pause_ack,
    output logic [31:0] incr_cnt,
    output logic [31:0] drop_cnt,
    page_access_incr_if.slave bus
);

    localparam int LANES  = DATA_W / CNT_W;
    localparam int LANE_W = $clog2(LANES);
    localparam int IDX_W  = ADDR_W + LANE_W;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_PAUSED
    } state_t;

    state_t state;

    logic              s1_valid;
    logic              s1_in_range;
    logic [ADDR_W-1:0] s1_word;
    logic [LANE_W-1:0] s1_lane;

    logic              fwd_valid;
    logic [ADDR_W-1:0] fwd_addr;
    logic [DATA_W-1:0] fwd_data;

    logic [31:0]       incr_q;
    logic [31:0]       drop_q;

    logic [63:0]       off;
    logic [63:0]       page;
    logic              in_range;
    logic [LANE_W-1:0] req_lane;
    logic [ADDR_W-1:0] req_word;
    logic              accept;

    logic [DATA_W-1:0] base;
    logic [DATA_W-1:0] new_word;
    logic [CNT_W-1:0]  field;
    logic              saturated;
    logic              do_write;
    logic              do_drop;

    // Map the FIFO head address to (word, lane); anything below the region or
    // beyond the last counter is flagged out of range.
    always_comb begin
        off      = bus.req_addr - region_base;
        page     = off >> PAGE_SHIFT;
        req_lane = page[LANE_W-1:0];
        req_word = page[LANE_W +: ADDR_W];
        in_range = (bus.req_addr >= region_base) && ((page >> IDX_W) == 64'd0);
    end

    // A request is popped only in RUN with no hold and no pending pause.
    assign accept = reset_n && (state == ST_RUN) && bus.req_valid
                    && !hold_reqfifo && !pause_req;

    // S1 update: pick the freshest copy of the word (the forwarding register
    // covers the SRAM returning old data right after a same-word write), then
    // bump the selected lane unless it is already saturated.
    always_comb begin
        base     = (fwd_valid && (fwd_addr == s1_word)) ? fwd_data : bus.buf_q;
        field    = '0;
        for (int i = 0; i < LANES; i++) begin
            if (s1_lane == LANE_W'(i)) begin
                field = base[i*CNT_W +: CNT_W];
            end
        end
        saturated = &field;
        new_word  = base;
        for (int i = 0; i < LANES; i++) begin
            if (s1_lane == LANE_W'(i)) begin
                new_word[i*CNT_W +: CNT_W] = field + CNT_W'(1);
            end
        end
        do_write = reset_n && s1_valid && s1_in_range && !saturated;
        do_drop  = reset_n && s1_valid && (!s1_in_range || saturated);
    end

    assign bus.req_ready     = accept;
    assign bus.buf_rdaddress = (accept && in_range) ? req_word : '0;
    assign bus.buf_wren      = do_write;
    assign bus.buf_wraddress = do_write ? s1_word : '0;
    assign bus.buf_data      = do_write ? new_word : '0;

    // Acknowledge once nothing is in flight; DRAIN with an empty S1 already
    // counts as parked, so the ack does not wait an extra cycle.
    assign pause_ack = reset_n && ((state == ST_PAUSED)
                       || ((state == ST_DRAIN) && pause_req && !s1_valid));

    assign incr_cnt = reset_n ? incr_q : '0;
    assign drop_cnt = reset_n ? drop_q : '0;

    // Ownership FSM: RUN accepts, DRAIN lets S1 finish, PAUSED leaves the SRAM alone.
    always_ff @(posedge mclk) begin
        if (!reset_n) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (pause_req) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!pause_req)    state <= ST_RUN;
                    else if (!s1_valid) state <= ST_PAUSED;
                end
                ST_PAUSED: begin
                    if (!pause_req) state <= ST_RUN;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    // S0 -> S1 register: the accepted request's word, lane and range flag.
    always_ff @(posedge mclk) begin
        if (!reset_n) begin
            s1_valid    <= 1'b0;
            s1_in_range <= 1'b0;
            s1_word     <= '0;
            s1_lane     <= '0;
        end else begin
            s1_valid    <= accept;
            s1_in_range <= in_range;
            s1_word     <= req_word;
            s1_lane     <= req_lane;
        end
    end

    // Forwarding register: remembers only the write made in the previous cycle.
    always_ff @(posedge mclk) begin
        if (!reset_n) begin
            fwd_valid <= 1'b0;
            fwd_addr  <= '0;
            fwd_data  <= '0;
        end else begin
            fwd_valid <= do_write;
            if (do_write) begin
                fwd_addr <= s1_word;
                fwd_data <= new_word;
            end
        end
    end

    // Statistics counters, wrapping at 2^32.
    always_ff @(posedge mclk) begin
        if (!reset_n) begin
            incr_q <= '0;
            drop_q <= '0;
        end else begin
            if (do_write) incr_q <= incr_q + 32'd1;
            if (do_drop)  drop_q <= drop_q + 32'd1;
        end
    end

endmodule
